// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage valid/ready pipeline registers.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Payload widths at each stage boundary of the five-stage core
  localparam int unsigned DATA_W_FD = 64;   // instr + PC8
  localparam int unsigned DATA_W_DE = 134;  // instr + PC8 + rs/rt values + write num + we
  localparam int unsigned DATA_W_EM = 134;  // instr + PC8 + alu result + rt value + write num + we
  localparam int unsigned DATA_W_MW = 102;  // instr + PC8 + result + write num + we

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready/data channel; master drives valid/data, slave drives ready.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// Single payload register with valid bit; sync clear and sync active-low reset load RESET_DATA.
module pipe_slot #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] data_d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else begin
      valid <= valid_d;
      if (load) data <= data_d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between adjacent stages with flush and saturating backpressure counter.
// Define PIPE_STAGE_SKID_EN to add the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       CNT_W      = 16,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] bp_cycles
);

  localparam logic [CNT_W-1:0] BP_MAX = '1;

  occ_e              state_q, state_d;
  logic              in_fire, out_fire;
  logic              m_valid, m_valid_d, m_load;
  logic [DATA_W-1:0] m_data, m_data_d;
`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid, s_valid_d, s_load;
  logic [DATA_W-1:0] s_data;
`endif

  assign in_fire   = up.valid && up.ready;
  assign out_fire  = m_valid && dn.ready;
  assign dn.valid  = m_valid;
  assign dn.data   = m_data;
  assign occupancy = OCC_W'(state_q);

`ifdef PIPE_STAGE_SKID_EN
  assign up.ready = !s_valid;
`else
  assign up.ready = !m_valid || dn.ready;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy and slot load controls; flush overrides everything below
  always_comb begin
    state_d   = state_q;
    m_load    = 1'b0;
    m_valid_d = m_valid;
    m_data_d  = up.data;
`ifdef PIPE_STAGE_SKID_EN
    s_load    = 1'b0;
    s_valid_d = s_valid;
    case (state_q)
      OCC_EMPTY: if (in_fire) begin
        m_load    = 1'b1;
        m_valid_d = 1'b1;
        state_d   = OCC_ONE;
      end
      OCC_ONE: if (in_fire && out_fire) begin
        m_load = 1'b1;
      end else if (in_fire) begin
        s_load    = 1'b1;
        s_valid_d = 1'b1;
        state_d   = OCC_FULL;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
        state_d   = OCC_EMPTY;
      end
      OCC_FULL: if (out_fire) begin
        m_load    = 1'b1;
        m_data_d  = s_data;
        s_valid_d = 1'b0;
        state_d   = OCC_ONE;
      end
      default: begin
        m_valid_d = 1'b0;
        s_valid_d = 1'b0;
        state_d   = OCC_EMPTY;
      end
    endcase
`else
    case (state_q)
      OCC_EMPTY: if (in_fire) begin
        m_load    = 1'b1;
        m_valid_d = 1'b1;
        state_d   = OCC_ONE;
      end
      // in_ready equals out_ready here, so an in-fire always coincides with an out-fire
      OCC_ONE: if (in_fire) begin
        m_load = 1'b1;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
        state_d   = OCC_EMPTY;
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = OCC_EMPTY;
      end
    endcase
`endif
    if (flush) state_d = OCC_EMPTY;
  end

  pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_m_slot (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (m_load),
    .valid_d (m_valid_d),
    .data_d  (m_data_d),
    .valid   (m_valid),
    .data    (m_data)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(.DATA_W(DATA_W), .RESET_DATA(RESET_DATA)) u_s_slot (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (s_load),
    .valid_d (s_valid_d),
    .data_d  (up.data),
    .valid   (s_valid),
    .data    (s_data)
  );
`endif

  // Saturating count of cycles where a presented payload is stalled; only reset clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      bp_cycles <= '0;
    end else if (m_valid && !dn.ready && bp_cycles != BP_MAX) begin
      bp_cycles <= bp_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle plus directed literal checks.
// Works for both builds (PIPE_STAGE_SKID_EN defined or not).
module tb_pipe_stage_reg;

  localparam int unsigned       DATA_W     = 32;
  localparam int unsigned       CNT_W      = 4;
  localparam logic [DATA_W-1:0] RESET_DATA = '0;
  localparam int                BP_MAX     = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic             clk = 1'b1;
  logic             reset;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] bp_cycles;

  pipe_stage_reg_if #(.DATA_W(DATA_W)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DATA_W)) dn_if ();

  pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RESET_DATA(RESET_DATA)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .occupancy (occupancy),
    .bp_cycles (bp_cycles)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO of held payloads, capacity CAP
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] delivered[$];
  logic [DATA_W-1:0] last_data = RESET_DATA;
  int                bp_model  = 0;
  bit                known     = 1'b0;

  always @(negedge clk) begin
    logic              exp_valid, exp_ready, in_fire, out_fire;
    logic [DATA_W-1:0] exp_data;
    exp_valid = (q.size() != 0);
    if (exp_valid) exp_data = q[0];
    else           exp_data = last_data;
    exp_ready = (q.size() < CAP) || (!SKID && dn_if.ready);
    if (known) begin
      chk("out_valid", dn_if.valid, exp_valid);
      chk("out_data",  dn_if.data,  exp_data);
      chk("in_ready",  up_if.ready, exp_ready);
      chk("occupancy", occupancy,   q.size());
      chk("bp_cycles", bp_cycles,   bp_model);
    end
    if (!reset) begin
      q.delete();
      last_data = RESET_DATA;
      bp_model  = 0;
      known     = 1'b1;
    end else if (known) begin
      if (dn_if.valid && dn_if.ready) delivered.push_back(dn_if.data);
      in_fire  = up_if.valid && exp_ready;
      out_fire = exp_valid && dn_if.ready;
      if (exp_valid && !dn_if.ready && bp_model < BP_MAX) bp_model++;
      if (out_fire) last_data = q.pop_front();
      if (flush) begin
        q.delete();
        last_data = RESET_DATA;
      end else if (in_fire) begin
        q.push_back(up_if.data);
      end
    end
  end

  task automatic set_in(input logic r, input logic f, input logic iv,
                        input logic [DATA_W-1:0] d, input logic ordy);
    reset       = r;
    flush       = f;
    up_if.valid = iv;
    up_if.data  = d;
    dn_if.ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    tick();
  endtask

  initial begin
    logic [DATA_W-1:0] items[3];
    logic              fired;
    logic              ordy;
    int                idx;

    // Reset held two cycles with a pending upstream payload
    set_in(1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1);
    tick();
    tick();
    chk("rst_out_valid", dn_if.valid, 1'b0);
    chk("rst_in_ready",  up_if.ready, 1'b1);
    chk("rst_out_data",  dn_if.data,  32'h0);
    chk("rst_bp",        bp_cycles,   0);
    chk("rst_occ",       occupancy,   0);

    // Streaming at full rate, first in-fire in the first cycle out of reset
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 1'b0, 1'b1, DATA_W'(i), 1'b1);
      tick();
      chk("stream_data",  dn_if.data,  DATA_W'(i));
      chk("stream_valid", dn_if.valid, 1'b1);
      chk("stream_occ",   occupancy,   1);
    end
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b1);
    tick();
    chk("stream_drain_valid", dn_if.valid, 1'b0);
    chk("stream_hold_data",   dn_if.data,  32'h8);

    // Backpressure for three cycles while upstream streams A, B, C
    do_reset();
    delivered.delete();
    items[0] = 32'hA;
    items[1] = 32'hB;
    items[2] = 32'hC;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      ordy = !(c >= 1 && c <= 3);
      set_in(1'b1, 1'b0, idx < 3, (idx < 3) ? items[idx] : '0, ordy);
      if (c == 2) begin
        #1;
        chk("skid_occ",      occupancy,   SKID ? 2 : 1);
        chk("skid_in_ready", up_if.ready, 1'b0);
      end
      @(negedge clk);
      fired = up_if.valid && up_if.ready;
      @(posedge clk);
      #1;
      if (fired) idx++;
    end
    chk("skid_count", delivered.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("skid_order", (k < delivered.size()) ? delivered[k] : 32'hFFFF_FFFF, items[k]);
    chk("skid_bp", bp_cycles, 3);

    // Flush from the fullest state, then flush during simultaneous in-fire and out-fire
    do_reset();
    delivered.delete();
    set_in(1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 32'h6, 1'b0);
    tick();
    chk("flush_pre_occ", occupancy, SKID ? 2 : 1);
    set_in(1'b1, 1'b1, 1'b1, 32'h7, 1'b0);
    tick();
    chk("flush_occ",   occupancy,   0);
    chk("flush_valid", dn_if.valid, 1'b0);
    chk("flush_data",  dn_if.data,  RESET_DATA);
    set_in(1'b1, 1'b0, 1'b1, 32'h8, 1'b1);
    tick();
    set_in(1'b1, 1'b1, 1'b1, 32'h9, 1'b1);
    tick();
    chk("flush2_occ",   occupancy,   0);
    chk("flush2_valid", dn_if.valid, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();
    chk("flush_delivered_count", delivered.size(), 1);
    chk("flush_delivered_8", (delivered.size() > 0) ? delivered[0] : 32'hFFFF_FFFF, 32'h8);

    // Counter saturation at 2^CNT_W-1, surviving a flush
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 32'h11, 1'b1);
    tick();
    repeat (20) begin
      set_in(1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick();
    end
    chk("sat_bp", bp_cycles, 15);
    set_in(1'b1, 1'b1, 1'b0, '0, 1'b0);
    tick();
    chk("sat_bp_after_flush", bp_cycles, 15);
    chk("sat_valid_after_flush", dn_if.valid, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    chk("sat_bp_hold", bp_cycles, 15);

    // Same-cycle in_ready response to out_ready with M occupied
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 32'h21, 1'b1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b0);
    #1;
    chk("comb_ready_low", up_if.ready, SKID ? 1'b1 : 1'b0);
    set_in(1'b1, 1'b0, 1'b1, 32'h22, 1'b1);
    #1;
    chk("comb_ready_high", up_if.ready, 1'b1);
    tick();
    chk("replace_data", dn_if.data, 32'h22);
    chk("replace_occ",  occupancy,  1);
    set_in(1'b1, 1'b0, 1'b0, '0, 1'b1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the fixed per-stage stall registers with a valid/ready handshake stage that carries an arbitrary-width payload. It adds flush (bubble injection), an optional two-entry skid buffer that decouples backpressure timing, and a saturating backpressure counter. One instance sits between each pair of adjacent stages (F/D, D/E, E/M, M/W). The hazard unit drives `flush`; `out_ready` deasserts wherever the old stall signal was asserted.

## Interface
- `DATA_W`, 32: payload width in bits; stages concatenate instr, PC8, operands, write number and write enable into this bus.
- `CNT_W`, 16: width of the backpressure counter.
- `RESET_DATA`, 0: value loaded into every payload register on reset and flush.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all held entries; the stage becomes a bubble.
- `in_valid`  in  1  upstream has a payload this cycle.
- `in_ready`  out  1  stage accepts a payload this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  stage presents a payload.
- `out_ready`  in  1  downstream consumes the payload this cycle (low = stall).
- `out_data`  out  DATA_W  presented payload.
- `occupancy`  out  2  number of held entries (0..2).
- `bp_cycles`  out  CNT_W  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Handshake terms:
  - in-fire = `in_valid && in_ready`.
  - out-fire = `out_valid && out_ready`.
  - `in_valid` is not required to remain asserted after a cycle in which in-fire did not occur.
- Storage:
  - main slot M (`m_valid`, `m_data`); `out_data` = `m_data` and `out_valid` = `m_valid`.
  - skid slot S (`s_valid`, `s_data`), present only when the skid buffer is compiled in (see Configuration).
- States are encoded by `occupancy`: EMPTY (0), ONE (1), FULL (2).
- Transitions with skid buffer (no flush):
  - EMPTY: in-fire → M←in, go to ONE.
  - ONE, in-fire and out-fire → M←in, stay in ONE.
  - ONE, in-fire only → S←in, go to FULL.
  - ONE, out-fire only → go to EMPTY.
  - ONE, neither → hold.
  - FULL: `in_ready`=0; out-fire → M←S, go to ONE; otherwise hold.
- `in_ready` = !`s_valid`. It is a registered function of state and never depends on `out_ready` in the same cycle.
- Flush has the highest priority:
  - next state is EMPTY, and M and S are both loaded with RESET_DATA.
  - an in-fire in the same cycle completes on the upstream side, and its payload is discarded.
  - an out-fire in the same cycle completes normally downstream.
- Payload stability: while `out_valid && !out_ready`, `out_data` stays bit-stable.
- Invalid data: when `out_valid`=0, `out_data` holds its last value (RESET_DATA after reset or flush).
- `bp_cycles` increments each backpressure cycle and saturates at 2^CNT_W−1. Flush does not clear it; only reset does.
- Order is preserved: first in, first out, with no duplication and no loss except on flush.

## Timing
- Latency: a payload accepted at edge N is visible on `out_data` after edge N (1 cycle).
- Throughput: 1 payload/cycle sustained while `out_ready`=1.
- Reset (`reset`=0 at an edge), at every output:
  - `out_valid`=0, `in_ready`=1, `occupancy`=0, `bp_cycles`=0, `out_data`=RESET_DATA.
  - reset overrides flush and any in-progress handshake.
- Reset taken mid-operation drops all entries. The first in-fire can occur in the first cycle with `reset`=1.
- With the skid buffer, one cycle of `out_ready`=0 never stalls upstream. Two consecutive cycles with backpressure while upstream is streaming drop `in_ready` on the second cycle.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - two-entry skid buffer as described above.
  - `in_ready` is registered.
  - `occupancy` ranges 0..2.
- `PIPE_STAGE_SKID_EN` undefined:
  - S is removed.
  - `in_ready` = !`m_valid` || `out_ready`, a combinational path from `out_ready`.
  - in ONE, in-fire together with out-fire replaces M.
  - `occupancy` ranges 0..1.
  - all other rules are unchanged.

## Structure
- Shared package `pipe_pkg`:
  - occupancy encodings `OCC_EMPTY`/`OCC_ONE`/`OCC_FULL`.
  - default `DATA_W` per stage boundary (FD, DE, EM, MW) as localparams.
- Sub-module `pipe_slot`: a DATA_W register plus valid bit, with load enable, sync clear to RESET_DATA and active-low sync reset. Instantiate it once for M and once for S when skid is compiled in.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `in_valid`=1, `in_data`=0xDEAD → `out_valid`=0, `in_ready`=1, `out_data`=0, `bp_cycles`=0.
- Stream: push 0x1..0x8 on consecutive cycles with `out_ready`=1 → outputs 0x1..0x8 one cycle later, no gaps, `occupancy` stays 1.
- Skid: stream 0xA, 0xB, 0xC with `out_ready`=0 from the cycle 0xA appears →
  - `occupancy`=2, `in_ready`=0 while 0xC is held upstream.
  - after `out_ready`=1, the order delivered is 0xA, 0xB, 0xC.
  - `bp_cycles` equals the number of stalled cycles.
- Flush with simultaneous in-fire: FULL holding 0x5, 0x6; assert `flush` with `in_valid`=1, 0x7 →
  - next cycle `occupancy`=0, `out_valid`=0, `out_data`=RESET_DATA.
  - 0x7 is never output.
- Counter saturation: CNT_W=4, hold backpressure 20 cycles → `bp_cycles`=15 and stays 15; a flush does not clear it.
- Non-skid build: `out_ready`=0 with M full → `in_ready`=0 in the same cycle. Then `out_ready`=1 with `in_valid`=1 → `in_ready`=1 in the same cycle and M is replaced.
